// File: rtl/mul_seq_8bit_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding and iteration count.
package mul_seq_8bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int MUL_ITER = 8;
  localparam logic [3:0] LAST_CNT = 4'(MUL_ITER - 1);

endpackage

// File: rtl/mul_seq_8bit_addsub.sv
// 8-bit adder stage reused by the multiplier; only the add path is exercised
// here (cin = 0), overflow is the signed-overflow flag of the sum.
module AddSub_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout,
  output logic       overflow
);

  logic [8:0] sum_s;

  assign sum_s    = {1'b0, a} + {1'b0, b} + {8'd0, cin};
  assign s        = sum_s[7:0];
  assign cout     = sum_s[8];
  assign overflow = (a[7] == b[7]) && (sum_s[7] != a[7]);

endmodule

// File: rtl/mul_seq_8bit.sv
// Sequential 8x8 unsigned shift-add multiplier: one add/shift per cycle through
// AddSub_8bit, 16-bit product and a one-cycle done pulse after 8 iterations.
module mul_seq_8bit
  import mul_seq_8bit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  m_r;
  logic [7:0]  acc_r;
  logic [7:0]  q_r;
  logic [3:0]  cnt_r;
  logic [15:0] product_r;
  logic        busy_r;
  logic        done_r;
  logic [7:0]  sum_s;
  logic        cout_s;
  logic [8:0]  partial_s;
  logic        last_iter_s;

  AddSub_8bit u_addsub (
    .a        (acc_r),
    .b        (m_r),
    .cin      (1'b0),
    .s        (sum_s),
    .cout     (cout_s),
    .overflow ()
  );

  assign last_iter_s = (cnt_r == LAST_CNT);

  // Partial product: add the multiplicand only when the current multiplier bit is set
  always_comb begin
    partial_s = {1'b0, acc_r};
    if (q_r[0]) begin
      partial_s = {cout_s, sum_s};
    end else begin
      partial_s = {1'b0, acc_r};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; start is only honoured in IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_iter_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Shift-add datapath; the product is captured on the final shift so it is valid in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r       <= 8'd0;
      acc_r     <= 8'd0;
      q_r       <= 8'd0;
      cnt_r     <= 4'd0;
      product_r <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            m_r   <= a;
            q_r   <= b;
            acc_r <= 8'd0;
            cnt_r <= 4'd0;
          end
        end
        ST_RUN: begin
          acc_r <= partial_s[8:1];
          q_r   <= {partial_s[0], q_r[7:1]};
          cnt_r <= cnt_r + 4'd1;
          if (last_iter_s) begin
            product_r <= {partial_s, q_r[7:1]};
          end
        end
        ST_DONE: begin
          cnt_r <= 4'd0;
        end
        default: begin
          cnt_r <= 4'd0;
        end
      endcase
    end
  end

  // Status flags registered from the next state so they line up with state_r
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ST_RUN);
      done_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule
